counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4, giving the step-count field width per command.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req0, req1  in  1 each  requester command request; held high with a stable command until its grant.
REQ-005 cmd0, cmd1  in  2 each  command: 00 NOP, 01 UP, 10 DOWN, 11 CLR.
REQ-006 len0, len1  in  LEN_W each  number of steps for UP/DOWN; ignored for CLR/NOP.
REQ-007 gnt0, gnt1  out  1 each  grant; command latched; one-cycle pulse.
REQ-008 done0, done1  out  1 each  command-complete pulse.
REQ-009 err0, err1  out  1 each  saturation abort, pulsed with the matching done.
REQ-010 c_ld, c_clr, op  out  1 each  datapath load, clear and direction (op=1 increment, op=0 decrement).
REQ-011 z, m  in  1 each  datapath flags: counter == 0 and counter == 0xFFFF, reflecting the registered counter value.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, GRANT, RUN and DONE; every transition occurs on a clk edge.
REQ-014 IDLE: if any req is high, pick a winner, latch its cmd/len/id and go to GRANT; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin over two requesters: on a tie, the requester not served last wins; a single request always wins.
REQ-016 GRANT: assert gnt of the winner for exactly one cycle.
REQ-017 GRANT, UP/DOWN with len>0: go to RUN with remaining=len.
REQ-018 GRANT, CLR: assert c_clr for that one cycle and go to DONE.
REQ-019 GRANT, NOP or len=0: go to DONE with no datapath activity.
REQ-020 RUN, each cycle: if (UP and m) or (DOWN and z), keep c_ld=0, set the abort flag and go to DONE.
REQ-021 RUN, otherwise: c_ld=1 with op set by the command, decrement remaining, and go to DONE when remaining reaches 0.
REQ-022 op SHALL hold the latched direction throughout RUN and SHALL be 0 elsewhere.
REQ-023 DONE: pulse done of the served requester for one cycle; pulse err in the same cycle if aborted.
REQ-024 DONE: record the served id as last-served and return to IDLE.
REQ-025 Latency: a req seen in IDLE at edge k SHALL give gnt in cycle k+1; an unsaturated len=N command SHALL give N c_ld cycles followed by done one cycle later.
REQ-026 c_ld and c_clr SHALL never be high in the same cycle; gnt0/gnt1, done0/done1 and err0/err1 are each mutually exclusive pairs.
REQ-027 Requests arriving while busy SHALL be held off, not lost; they are arbitrated at the next IDLE.
REQ-028 No wrap-around SHALL ever be commanded: the counter saturates at 0 and 0xFFFF.

Reset
REQ-029 While reset is low at an edge, the FSM SHALL go to IDLE with last-served=1, so requester 0 wins the first tie.
REQ-030 Reset SHALL clear all outputs to 0: gnt*, done*, err*, c_ld, c_clr, op and busy.
REQ-031 Reset mid-command SHALL discard the command with no done or err pulse; reset does not clear the datapath counter.

Structure
REQ-032 A shared package counter_ctrl_pkg SHALL hold the state encoding, the CMD_NOP/UP/DOWN/CLR constants and the default LEN_W.
REQ-033 The two-way round-robin pick SHALL be a sub-module rr_arbiter2 (inputs: req0, req1, last; output: winner id); the rest stays in counter_arbiter.

Verification
REQ-034 Counter=0; req0 UP len=3 -> gnt0 one cycle; c_ld=1,op=1 for 3 consecutive cycles; done0 pulse with err0=0; counter=3.
REQ-035 After reset, req0 UP len=2 and req1 DOWN len=1 raised in the same cycle -> gnt0 first, then gnt1, net counter +1; the next simultaneous pair is granted to req1 first.
REQ-036 Counter=2; req1 DOWN len=5 -> 2 c_ld cycles, z=1 stops it, done1 and err1 in the same cycle; counter=0.
REQ-037 Counter=0xFFFE; req0 UP len=4 -> 1 c_ld cycle, then abort; err0=1; counter=0xFFFF.
REQ-038 Counter=7; req1 CLR -> c_clr for one cycle with c_ld=0; done1 pulse; counter=0. req0 NOP -> done0 only, with no c_ld and no c_clr.
REQ-039 req0 UP len=6, reset low after the first c_ld -> the next cycle has all outputs 0 and the state is IDLE; no done0 pulse; counter=1.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared encodings and defaults for the two-requester counter command arbiter.
package counter_ctrl_pkg;

    localparam int unsigned LEN_W_DEF = 4;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;
    localparam logic [1:0] CMD_CLR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

    function automatic logic is_step(input logic [1:0] cmd);
        return (cmd == CMD_UP) || (cmd == CMD_DOWN);
    endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester, status and datapath-control signals between the arbiter and its environment.
interface counter_arbiter_if
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) ();

    logic             req0;
    logic             req1;
    logic [1:0]       cmd0;
    logic [1:0]       cmd1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             err0;
    logic             err1;
    logic             c_ld;
    logic             c_clr;
    logic             op;
    logic             z;
    logic             m;
    logic             busy;

    // Environment side: requesters plus the counter datapath flags.
    modport master (
        output req0, req1, cmd0, cmd1, len0, len1, z, m,
        input  gnt0, gnt1, done0, done1, err0, err1, c_ld, c_clr, op, busy
    );

    modport slave (
        input  req0, req1, cmd0, cmd1, len0, len1, z, m,
        output gnt0, gnt1, done0, done1, err0, err1, c_ld, c_clr, op, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Arbitrates UP/DOWN/CLR/NOP commands from two requesters onto a saturating counter datapath.
module counter_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input logic           clk,
    input logic           reset,
    counter_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             abort_q, abort_d;

    logic winner;
    logic gnt;
    logic done;
    logic c_ld;
    logic c_clr;
    logic op;
    logic sat;

    rr_arbiter2 u_rr (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_q),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            cmd_q   <= CMD_NOP;
            rem_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            cmd_q   <= cmd_d;
            rem_q   <= rem_d;
            abort_q <= abort_d;
        end
    end

    // Stepping in the saturated direction would wrap the counter.
    assign sat = ((cmd_q == CMD_UP) && bus.m) || ((cmd_q == CMD_DOWN) && bus.z);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        cmd_d   = cmd_q;
        rem_d   = rem_q;
        abort_d = abort_q;
        gnt     = 1'b0;
        done    = 1'b0;
        c_ld    = 1'b0;
        c_clr   = 1'b0;
        op      = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    id_d    = winner;
                    cmd_d   = winner ? bus.cmd1 : bus.cmd0;
                    rem_d   = winner ? bus.len1 : bus.len0;
                    abort_d = 1'b0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                gnt = 1'b1;
                if (cmd_q == CMD_CLR) begin
                    c_clr   = 1'b1;
                    state_d = StDone;
                end else if (is_step(cmd_q) && (rem_q != '0)) begin
                    state_d = StRun;
                end else begin
                    state_d = StDone;
                end
            end
            StRun: begin
                op = (cmd_q == CMD_UP);
                if (sat) begin
                    abort_d = 1'b1;
                    state_d = StDone;
                end else begin
                    c_ld  = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                last_d  = id_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.gnt0  = gnt & ~id_q;
    assign bus.gnt1  = gnt & id_q;
    assign bus.done0 = done & ~id_q;
    assign bus.done1 = done & id_q;
    assign bus.err0  = done & abort_q & ~id_q;
    assign bus.err1  = done & abort_q & id_q;
    assign bus.c_ld  = c_ld;
    assign bus.c_clr = c_clr;
    assign bus.op    = op;
    assign bus.busy  = (state_q != StIdle);

    a_ld_clr_excl: assert property (@(posedge clk) disable iff (!reset) !(c_ld && c_clr));
    a_gnt_pulse: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StGrant) |=> (state_q != StGrant));

endmodule

// File: tb/tb_counter_arbiter.sv
// Randomised and directed checks of counter_arbiter against a transaction-level reference model.
module tb_counter_arbiter;
    import counter_ctrl_pkg::*;

    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_arbiter_if #(.LEN_W(LW)) bus ();

    counter_arbiter #(.LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Counter datapath owned by the bench; it is not touched by reset.
    logic [15:0] cnt;
    logic        preset_en;
    logic [15:0] preset_val;
    always @(posedge clk) begin
        if (preset_en) cnt <= preset_val;
        else if (bus.c_clr) cnt <= 16'h0000;
        else if (bus.c_ld) cnt <= bus.op ? cnt + 16'd1 : cnt - 16'd1;
    end
    assign bus.z = (cnt == 16'h0000);
    assign bus.m = (cnt == 16'hFFFF);

    int n_chk  = 0;
    int n_fail = 0;
    int model_cnt;
    int last_m;
    bit mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                bus.c_ld, bus.c_clr, bus.op, bus.busy};
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            chk("exclusive_pairs",
                {bus.c_ld & bus.c_clr, bus.gnt0 & bus.gnt1, bus.done0 & bus.done1,
                 bus.err0 & bus.err1}, 0);
            chk("no_wrap", bus.c_ld && ((bus.op && cnt == 16'hFFFF) || (!bus.op && cnt == 0)), 0);
        end
    end

    function automatic int rr(input bit r0, input bit r1, input int last);
        if (r0 && r1) return (last == 1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    // Effect of one command: steps taken, abort flag and resulting counter.
    task automatic predict(input logic [1:0] cmd, input int len, input int c,
                           output int l, output int e, output int nc);
        int room;
        l = 0; e = 0; nc = c;
        if (cmd == CMD_UP || cmd == CMD_DOWN) begin
            room = (cmd == CMD_UP) ? 65535 - c : c;
            l    = (len < room) ? len : room;
            e    = (len > room) ? 1 : 0;
            nc   = (cmd == CMD_UP) ? c + l : c - l;
        end else if (cmd == CMD_CLR) begin
            nc = 0;
        end
    endtask

    task automatic set_req(input int id, input bit en, input logic [1:0] cmd, input int len);
        if (id == 0) begin
            bus.req0 = en; bus.cmd0 = cmd; bus.len0 = LW'(len);
        end else begin
            bus.req1 = en; bus.cmd1 = cmd; bus.len1 = LW'(len);
        end
    endtask

    task automatic set_cnt(input int v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = 16'(v);
        @(negedge clk);
        preset_en  = 1'b0;
        model_cnt  = v;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_req(0, 0, CMD_NOP, 0);
        set_req(1, 0, CMD_NOP, 0);
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        reset  = 1'b1;
        last_m = 1;
    endtask

    // Wait for one grant, then follow that command to its done pulse.
    task automatic serve(input int id, input logic [1:0] cmd, input int len, input int gap,
                         input bit reraise, input logic [1:0] rcmd, input int rlen);
        int waited, cyc, ld_n, clr_n, op_bad, l, e, nc;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(bus.gnt0 || bus.gnt1) && waited < 20);
        chk("gnt_latency", waited, gap);
        chk("gnt_id", {bus.gnt1, bus.gnt0}, (id == 0) ? 1 : 2);
        chk("gnt_clr", bus.c_clr, (cmd == CMD_CLR) ? 1 : 0);
        chk("gnt_ld_op", {bus.c_ld, bus.op}, 0);
        predict(cmd, len, model_cnt, l, e, nc);
        set_req(id, reraise, rcmd, rlen);
        cyc = 0; ld_n = 0; clr_n = 0; op_bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!(bus.done0 || bus.done1)) begin
                ld_n   += bus.c_ld ? 1 : 0;
                clr_n  += bus.c_clr ? 1 : 0;
                op_bad += (bus.op !== (cmd == CMD_UP)) ? 1 : 0;
            end
        end while (!(bus.done0 || bus.done1) && cyc < 40);
        chk("done_latency", cyc, 1 + l + e);
        chk("done_id", {bus.done1, bus.done0}, (id == 0) ? 1 : 2);
        chk("err", {bus.err1, bus.err0}, (e != 0) ? ((id == 0) ? 1 : 2) : 0);
        chk("ld_cycles", ld_n, l);
        chk("run_clr", clr_n, 0);
        chk("run_op", op_bad, 0);
        chk("done_ld_clr_op", {bus.c_ld, bus.c_clr, bus.op}, 0);
        model_cnt = nc;
        last_m    = id;
        chk("counter", cnt, model_cnt);
    endtask

    task automatic round(input bit e0, input logic [1:0] c0, input int l0,
                         input bit e1, input logic [1:0] c1, input int l1);
        int w;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        set_req(0, e0, c0, l0);
        set_req(1, e1, c1, l1);
        w = rr(e0, e1, last_m);
        if (w == 0) serve(0, c0, l0, 1, 0, CMD_NOP, 0);
        else        serve(1, c1, l1, 1, 0, CMD_NOP, 0);
        if (e0 && e1) begin
            if (w == 0) serve(1, c1, l1, 2, 0, CMD_NOP, 0);
            else        serve(0, c0, l0, 2, 0, CMD_NOP, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited, dn, sel;
        bit e0, e1;
        reset      = 1'b0;
        preset_en  = 1'b0;
        preset_val = '0;
        model_cnt  = 0;
        last_m     = 1;
        do_reset();
        mon_on = 1'b1;

        // UP by 3 from zero.
        set_cnt(0);
        round(1, CMD_UP, 3, 0, CMD_NOP, 0);

        // Tie after reset goes to req0; req0 re-requests, so the next tie goes to req1.
        do_reset();
        set_cnt(0);
        @(negedge clk);
        set_req(0, 1, CMD_UP, 2);
        set_req(1, 1, CMD_DOWN, 1);
        serve(0, CMD_UP, 2, 1, 1, CMD_UP, 1);
        serve(1, CMD_DOWN, 1, 2, 0, CMD_NOP, 0);
        chk("pair_net", cnt, 1);
        serve(0, CMD_UP, 1, 2, 0, CMD_NOP, 0);

        // Saturation aborts at both ends.
        set_cnt(2);
        round(0, CMD_NOP, 0, 1, CMD_DOWN, 5);
        set_cnt(16'hFFFE);
        round(1, CMD_UP, 4, 0, CMD_NOP, 0);

        // CLR then NOP.
        set_cnt(7);
        round(0, CMD_NOP, 0, 1, CMD_CLR, 0);
        round(1, CMD_NOP, 0, 0, CMD_NOP, 0);

        // Reset after the first step of a 6-step UP.
        set_cnt(0);
        @(negedge clk);
        set_req(0, 1, CMD_UP, 6);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.gnt0 && waited < 10);
        chk("midrst_gnt", waited, 1);
        set_req(0, 0, CMD_NOP, 0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.c_ld && waited < 10);
        chk("midrst_first_ld", waited, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", outs(), 0);
        chk("midrst_counter", cnt, 1);
        reset = 1'b1;
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            dn += (bus.done0 | bus.done1 | bus.err0 | bus.err1) ? 1 : 0;
        end
        chk("midrst_no_done", dn, 0);
        model_cnt = 1;
        last_m    = 1;

        // Random traffic, with the counter sometimes parked near a bound.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) set_cnt($urandom_range(0, 3));
            else if (sel == 1) set_cnt($urandom_range(65532, 65535));
            e0 = 1'($urandom_range(0, 1));
            e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
            round(e0, 2'($urandom_range(0, 3)), $urandom_range(0, 15),
                  e1, 2'($urandom_range(0, 3)), $urandom_range(0, 15));
        end

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
